// File: rtl/ota_duty_meter.sv
// Comparator back-end: synchronizes and deglitches the OTA output, then measures
// high-time and rising-edge count over a 2^WIN_LOG2 clock window with a valid/ack readout.
module ota_duty_meter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int WIN_LOG2    = 8,
  parameter int EDGE_W      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                cmp_in,
  input  logic                start,
  input  logic                continuous,
  input  logic                result_ack,
  output logic                cmp_filt,
  output logic                busy,
  output logic [WIN_LOG2:0]   duty,
  output logic [EDGE_W-1:0]   edges,
  output logic                result_valid,
  output logic                overrun
);

  localparam int DW = WIN_LOG2 + 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Handshake: result_valid rises when a window publishes and stays high until the
  // consumer pulses result_ack; an ack in the publish cycle keeps the new result valid.

  state_t              state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FILT_LEN-1:0] hist_q, hist_d;
  logic                cmp_filt_q, cmp_filt_d;
  logic                filt_prev_q, filt_prev_d;
  logic [WIN_LOG2-1:0] win_cnt_q, win_cnt_d;
  logic [DW-1:0]       hi_cnt_q, hi_cnt_d;
  logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [DW-1:0]       duty_q, duty_d;
  logic [EDGE_W-1:0]   edges_q, edges_d;
  logic                result_valid_q, result_valid_d;
  logic                overrun_q, overrun_d;
  logic                busy_q, busy_d;

  logic                rise;
  logic                publish;
  logic [DW-1:0]       hi_sum;
  logic [EDGE_W-1:0]   edge_next;

  always_comb begin
    sync_d = sync_q;
    sync_d[0] = cmp_in;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];

    hist_d = hist_q;
    hist_d[0] = sync_q[SYNC_STAGES-1];
    for (int i = 1; i < FILT_LEN; i++) hist_d[i] = hist_q[i-1];

    // Level changes only once the whole history agrees; mixed history holds.
    cmp_filt_d = cmp_filt_q;
    if (&hist_q)       cmp_filt_d = 1'b1;
    else if (~|hist_q) cmp_filt_d = 1'b0;

    filt_prev_d = cmp_filt_q;

    rise      = cmp_filt_q & ~filt_prev_q;
    hi_sum    = hi_cnt_q + DW'(cmp_filt_q);
    edge_next = (rise && (edge_cnt_q != '1)) ? edge_cnt_q + EDGE_W'(1) : edge_cnt_q;

    state_d        = state_q;
    win_cnt_d      = win_cnt_q;
    hi_cnt_d       = hi_cnt_q;
    edge_cnt_d     = edge_cnt_q;
    duty_d         = duty_q;
    edges_d        = edges_q;
    result_valid_d = result_valid_q;
    overrun_d      = overrun_q;
    publish        = 1'b0;

    case (state_q)
      S_IDLE: begin
        win_cnt_d  = '0;
        hi_cnt_d   = '0;
        edge_cnt_d = '0;
        if (start && ena) state_d = S_RUN;
      end
      S_RUN: begin
        if (!ena) begin
          state_d    = S_IDLE;
          win_cnt_d  = '0;
          hi_cnt_d   = '0;
          edge_cnt_d = '0;
        end else if (&win_cnt_q) begin
          publish    = 1'b1;
          duty_d     = hi_sum;
          edges_d    = edge_next;
          win_cnt_d  = '0;
          hi_cnt_d   = '0;
          edge_cnt_d = '0;
          state_d    = continuous ? S_RUN : S_IDLE;
        end else begin
          win_cnt_d  = win_cnt_q + WIN_LOG2'(1);
          hi_cnt_d   = hi_sum;
          edge_cnt_d = edge_next;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (publish) begin
      result_valid_d = 1'b1;
      if (result_ack)          overrun_d = 1'b0;
      else if (result_valid_q) overrun_d = 1'b1;
    end else if (result_ack) begin
      result_valid_d = 1'b0;
      overrun_d      = 1'b0;
    end

    busy_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      sync_q         <= '0;
      hist_q         <= '0;
      cmp_filt_q     <= 1'b0;
      filt_prev_q    <= 1'b0;
      win_cnt_q      <= '0;
      hi_cnt_q       <= '0;
      edge_cnt_q     <= '0;
      duty_q         <= '0;
      edges_q        <= '0;
      result_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync_q         <= sync_d;
      hist_q         <= hist_d;
      cmp_filt_q     <= cmp_filt_d;
      filt_prev_q    <= filt_prev_d;
      win_cnt_q      <= win_cnt_d;
      hi_cnt_q       <= hi_cnt_d;
      edge_cnt_q     <= edge_cnt_d;
      duty_q         <= duty_d;
      edges_q        <= edges_d;
      result_valid_q <= result_valid_d;
      overrun_q      <= overrun_d;
      busy_q         <= busy_d;
    end
  end

  assign cmp_filt     = cmp_filt_q;
  assign busy         = busy_q;
  assign duty         = duty_q;
  assign edges        = edges_q;
  assign result_valid = result_valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_ota_duty_meter.sv
// Bench for ota_duty_meter: periodic-pattern vector table with a result queue,
// plus sequences for overrun, enable abort and asynchronous reset.
module tb_ota_duty_meter;

  logic       clk = 1'b0;
  logic       clk_en = 1'b1;
  logic       rst_n = 1'b1;
  logic       ena = 1'b0;
  logic       cmp_in = 1'b0;
  logic       start = 1'b0;
  logic       continuous = 1'b0;
  logic       result_ack = 1'b0;
  logic       cmp_filt;
  logic       busy;
  logic [8:0] duty;
  logic [7:0] edges;
  logic       result_valid;
  logic       overrun;

  ota_duty_meter dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cmp_in(cmp_in), .start(start),
    .continuous(continuous), .result_ack(result_ack), .cmp_filt(cmp_filt),
    .busy(busy), .duty(duty), .edges(edges), .result_valid(result_valid),
    .overrun(overrun)
  );

  // clock / reset
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // periodic cmp_in driver, synchronous to negedge
  int  pat_per = 1;
  int  pat_hi  = 0;
  bit  pat_en  = 1'b1;
  int  ph      = 0;
  always @(negedge clk) begin
    if (pat_en) begin
      cmp_in = (ph < pat_hi);
      ph = (ph + 1 >= pat_per) ? 0 : ph + 1;
    end
  end

  // glitch monitor
  bit mon_en = 1'b0;
  bit filt_seen = 1'b0;
  always @(negedge clk) if (mon_en && cmp_filt) filt_seen = 1'b1;

  // scoreboard
  logic [16:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name);
    logic [16:0] e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: no expected entry queued, got duty=%0d edges=%0d", name, duty, edges);
    end else begin
      e = exp_q.pop_front();
      if ({duty, edges} !== e) begin
        n_err++;
        $display("FAIL %s: got duty=%0d edges=%0d, expected duty=%0d edges=%0d",
                 name, duty, edges, e[16:8], e[7:0]);
      end
    end
  endtask

  // sel=0 waits for result_valid, sel=1 for overrun; timeout counts as a miscompare
  task automatic wait_flag(input bit sel, input string name);
    int n = 0;
    @(negedge clk);
    while (!(sel ? overrun : result_valid) && n < 700) begin
      @(negedge clk);
      n++;
    end
    if (n >= 700) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: timeout waiting for %s, got 0, expected 1", name,
               sel ? "overrun" : "result_valid");
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic pulse_ack();
    @(negedge clk) result_ack = 1'b1;
    @(negedge clk) result_ack = 1'b0;
  endtask

  task automatic set_pat(input int per, input int hi);
    pat_per = per;
    pat_hi  = hi;
    repeat (80) @(negedge clk);
  endtask

  typedef struct {
    int         per;
    int         hi;
    logic [8:0] duty;
    logic [7:0] edges;
    bit         glitch;
  } vec_t;
  vec_t vecs[8];

  initial begin
    vecs[0] = '{1, 1, 9'd256, 8'd0, 1'b0};
    vecs[1] = '{16, 8, 9'd128, 8'd16, 1'b0};
    vecs[2] = '{32, 8, 9'd64, 8'd8, 1'b0};
    vecs[3] = '{64, 48, 9'd192, 8'd4, 1'b0};
    vecs[4] = '{8, 3, 9'd96, 8'd32, 1'b0};
    vecs[5] = '{10, 1, 9'd0, 8'd0, 1'b1};
    vecs[6] = '{10, 2, 9'd0, 8'd0, 1'b1};
    vecs[7] = '{1, 0, 9'd0, 8'd0, 1'b0};

    // reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_duty", duty, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_overrun", overrun, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ena = 1'b1;

    // table vectors
    foreach (vecs[i]) begin
      set_pat(vecs[i].per, vecs[i].hi);
      filt_seen = 1'b0;
      mon_en = vecs[i].glitch;
      pulse_start();
      chk($sformatf("v%0d_busy_run", i), busy, 1);
      exp_q.push_back({vecs[i].duty, vecs[i].edges});
      wait_flag(1'b0, $sformatf("v%0d_wait", i));
      mon_en = 1'b0;
      sb_check($sformatf("v%0d_result", i));
      chk($sformatf("v%0d_busy_done", i), busy, 0);
      if (vecs[i].glitch) chk($sformatf("v%0d_glitch_filt", i), filt_seen, 0);
      pulse_ack();
      chk($sformatf("v%0d_ack_valid", i), result_valid, 0);
    end

    // continuous mode: overrun, ack clears, ack on publish cycle
    set_pat(1, 1);
    continuous = 1'b1;
    pulse_start();
    exp_q.push_back({9'd256, 8'd0});
    wait_flag(1'b0, "cont_w1_wait");
    sb_check("cont_w1");
    pat_en = 1'b0;
    cmp_in = 1'b0;
    exp_q.push_back({9'd6, 8'd0});
    wait_flag(1'b1, "cont_w2_wait");
    sb_check("cont_w2");
    chk("cont_w2_valid", result_valid, 1);
    chk("cont_w2_overrun", overrun, 1);
    pulse_ack();
    chk("cont_ack_valid", result_valid, 0);
    chk("cont_ack_overrun", overrun, 0);
    exp_q.push_back({9'd0, 8'd0});
    wait_flag(1'b0, "cont_w3_wait");
    sb_check("cont_w3");
    chk("cont_w3_overrun", overrun, 0);
    repeat (255) @(posedge clk);
    @(negedge clk) result_ack = 1'b1;
    @(negedge clk) result_ack = 1'b0;
    exp_q.push_back({9'd0, 8'd0});
    sb_check("cont_w4");
    chk("cont_w4_valid", result_valid, 1);
    chk("cont_w4_overrun", overrun, 0);
    continuous = 1'b0;
    @(negedge clk) ena = 1'b0;
    @(negedge clk) ena = 1'b1;
    chk("cont_stop_busy", busy, 0);
    pulse_ack();
    pat_en = 1'b1;

    // ena abort at RUN cycle 100, then a fresh full window
    set_pat(32, 8);
    pulse_start();
    exp_q.push_back({9'd64, 8'd8});
    wait_flag(1'b0, "abort_pre_wait");
    sb_check("abort_pre");
    set_pat(16, 8);
    pulse_start();
    repeat (99) @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_duty", duty, 64);
    chk("abort_edges", edges, 8);
    chk("abort_valid", result_valid, 1);
    ena = 1'b1;
    pulse_start();
    exp_q.push_back({9'd128, 8'd16});
    wait_flag(1'b1, "abort_fresh_wait");
    sb_check("abort_fresh");
    chk("abort_fresh_overrun", overrun, 1);

    // async reset mid-RUN with the clock stopped
    pulse_start();
    repeat (50) @(negedge clk);
    chk("arst_pre_busy", busy, 1);
    clk_en = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_cmp_filt", cmp_filt, 0);
    chk("arst_busy", busy, 0);
    chk("arst_duty", duty, 0);
    chk("arst_edges", edges, 0);
    chk("arst_valid", result_valid, 0);
    chk("arst_overrun", overrun, 0);
    #3 rst_n = 1'b1;
    #2 clk_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("arst_post_busy", busy, 0);
    chk("arst_post_valid", result_valid, 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
